// File: rtl/imem_port_arbiter_if.sv
// Bundles the fetch, loader and instruction-memory port signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding fetch/loader/memory side.
interface imem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_rvalid;
    logic [31:0]           fetch_rdata;

    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [31:0]           ld_wdata;
    logic                  ld_lock;
    logic                  ld_gnt;
    logic                  ld_rvalid;
    logic [31:0]           ld_rdata;

    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_in;
    logic [31:0]           mem_data_out;

    modport slave (
        input  fetch_req, fetch_addr,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  mem_data_out,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_re, mem_we, mem_address, mem_data_in
    );

    modport master (
        output fetch_req, fetch_addr,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output mem_data_out,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_re, mem_we, mem_address, mem_data_in
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single synchronous instruction-memory port between fetch (read-only) and the
// loader/debug port (read/write), with starvation boost, download lock and 1-cycle read routing.
module imem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                IMA_Clk,
    input  logic                IMA_Reset_InLow,
    imem_port_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {FETCH_PRIO, LD_BOOST, LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LD} owner_t;

    state_t           state;
    owner_t           rd_owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             run;
    logic             fetch_gnt_c;
    logic             ld_gnt_c;
    logic             rd_grant_c;

    // run holds every grant low during reset and the first cycle after release
    always_comb begin
        fetch_gnt_c = 1'b0;
        ld_gnt_c    = 1'b0;
        if (run) begin
            case (state)
                FETCH_PRIO: begin
                    fetch_gnt_c = bus.fetch_req;
                    ld_gnt_c    = bus.ld_req & ~bus.fetch_req;
                end
                LD_BOOST: begin
                    ld_gnt_c    = bus.ld_req;
                    fetch_gnt_c = bus.fetch_req & ~bus.ld_req;
                end
                LOCKED: begin
                    ld_gnt_c = bus.ld_req;
                end
                default: begin
                    fetch_gnt_c = 1'b0;
                    ld_gnt_c    = 1'b0;
                end
            endcase
        end
    end

    assign rd_grant_c = fetch_gnt_c | (ld_gnt_c & ~bus.ld_we);

    assign bus.fetch_gnt   = fetch_gnt_c;
    assign bus.ld_gnt      = ld_gnt_c;
    assign bus.mem_we      = ld_gnt_c & bus.ld_we;
    assign bus.mem_address = fetch_gnt_c ? bus.fetch_addr :
                             ld_gnt_c    ? bus.ld_addr    : ADDR_WIDTH'(0);
    assign bus.mem_data_in = ld_gnt_c ? bus.ld_wdata : 32'h0;

    // Response side: the owner recorded at the grant edge steers the memory word
    assign bus.mem_re       = (rd_owner != OWN_NONE);
    assign bus.fetch_rvalid = (rd_owner == OWN_FETCH);
    assign bus.ld_rvalid    = (rd_owner == OWN_LD);
    assign bus.fetch_rdata  = (rd_owner == OWN_FETCH) ? bus.mem_data_out : 32'h0;
    assign bus.ld_rdata     = (rd_owner == OWN_LD)    ? bus.mem_data_out : 32'h0;

    always_ff @(posedge IMA_Clk or negedge IMA_Reset_InLow) begin
        if (!IMA_Reset_InLow) begin
            state      <= FETCH_PRIO;
            rd_owner   <= OWN_NONE;
            starve_cnt <= '0;
            run        <= 1'b0;
        end else begin
            run <= 1'b1;

            if (fetch_gnt_c)     rd_owner <= OWN_FETCH;
            else if (rd_grant_c) rd_owner <= OWN_LD;
            else                 rd_owner <= OWN_NONE;

            if (bus.ld_lock) begin
                state      <= LOCKED;
                starve_cnt <= '0;
            end else begin
                case (state)
                    FETCH_PRIO: begin
                        if (bus.ld_req && fetch_gnt_c) begin
                            if (starve_cnt != CNT_W'(STARVE_MAX))
                                starve_cnt <= starve_cnt + CNT_W'(1);
                            if (starve_cnt == CNT_W'(STARVE_MAX - 1))
                                state <= LD_BOOST;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                    LD_BOOST: begin
                        starve_cnt <= '0;
                        if (ld_gnt_c || !bus.ld_req)
                            state <= FETCH_PRIO;
                    end
                    LOCKED: begin
                        starve_cnt <= '0;
                        state      <= FETCH_PRIO;
                    end
                    default: begin
                        starve_cnt <= '0;
                        state      <= FETCH_PRIO;
                    end
                endcase
            end
        end
    end
endmodule
